// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the character LCD controller.
package lcd_pkg;

    localparam int unsigned STATE_W = 3;

    // Main controller states
    localparam logic [STATE_W-1:0] ST_PWR   = 3'd0;
    localparam logic [STATE_W-1:0] ST_INIT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETUP = 3'd3;
    localparam logic [STATE_W-1:0] ST_PULSE = 3'd4;
    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd5;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd6;
    localparam logic [STATE_W-1:0] ST_WRAP  = 3'd7;

    // HD44780 instruction codes
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_DDRAM    = 8'h80;
    localparam logic [7:0] LINE1_BASE   = 8'h40;

    localparam int unsigned INIT_LEN = 4;

    // Clear and home need the long execution wait
    function automatic logic is_long_cmd(input logic [7:0] cmd);
        return (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
    endfunction

    // Power-on init sequence, issued in index order
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Largest of three cycle counts, used to size the shared timer
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter: runs load_val cycles after start, done_c marks the last one.
module lcd_wait_timer #(
    parameter int unsigned W        = 8,
    parameter int unsigned RST_LOAD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    // Load on start, otherwise count down to zero and stop
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = load_val - W'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Counter registers; reset leaves the power-on wait already running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= W'(RST_LOAD - 1);
            run_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_c = run_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-class 8-bit write-only LCD controller with init sequencing and cursor tracking.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned COLS       = 16,
    parameter int unsigned LINES      = 2,
    parameter int unsigned E_CYCLES   = 25,
    parameter int unsigned SHORT_WAIT = 2000,
    parameter int unsigned LONG_WAIT  = 82000,
    parameter int unsigned PWR_WAIT   = 750000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_rs,
    input  logic [7:0]                 in_data,
    output logic                       init_done,
    output logic                       lcd_e,
    output logic                       lcd_rs,
    output logic                       lcd_rw,
    output logic [7:0]                 lcd_data,
    output logic                       cur_line,
    output logic [$clog2(COLS+1)-1:0]  cur_col
);

    localparam int unsigned CW = $clog2(COLS + 1);
    localparam int unsigned TW = $clog2(max3(PWR_WAIT, LONG_WAIT, E_CYCLES) + 1);

    localparam logic [TW-1:0] E_LOAD     = TW'(E_CYCLES);
    localparam logic [TW-1:0] SHORT_LOAD = TW'(SHORT_WAIT);
    localparam logic [TW-1:0] LONG_LOAD  = TW'(LONG_WAIT);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               long_q, long_d;
    logic               wrap_q, wrap_d;
    logic               init_done_q, init_done_d;
    logic               in_ready_q, in_ready_d;
    logic               lcd_e_q, lcd_e_d;
    logic               lcd_rs_q, lcd_rs_d;
    logic [7:0]         lcd_data_q, lcd_data_d;
    logic               line_q, line_d;
    logic [CW-1:0]      col_q, col_d;

    logic               tmr_start_c;
    logic [TW-1:0]      tmr_load_c;
    logic               tmr_done_c;
    logic [1:0]         next_idx_c;
    logic [7:0]         wrap_cmd_c;

    // Shared timer for power-on wait, E pulse width and post-write wait
    lcd_wait_timer #(
        .W        (TW),
        .RST_LOAD (PWR_WAIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start_c),
        .load_val (tmr_load_c),
        .done_c   (tmr_done_c)
    );

    assign next_idx_c = idx_q + 2'd1;
    assign wrap_cmd_c = CMD_DDRAM | (((LINES == 32'd2) && line_q) ? LINE1_BASE : 8'h00);

    // Next-state, bus payload, cursor tracking and registered output decode
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        long_d      = long_q;
        wrap_d      = wrap_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        line_d      = line_q;
        col_d       = col_q;
        tmr_start_c = 1'b0;
        tmr_load_c  = E_LOAD;

        case (state_q)
            ST_PWR: begin
                if (tmr_done_c) begin
                    state_d    = ST_INIT;
                    idx_d      = 2'd0;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(2'd0);
                    long_d     = is_long_cmd(init_cmd(2'd0));
                end
            end
            // All three act as the one-cycle setup ahead of the E pulse
            ST_INIT, ST_SETUP, ST_WRAP: begin
                state_d     = ST_PULSE;
                tmr_start_c = 1'b1;
                tmr_load_c  = E_LOAD;
            end
            ST_PULSE: begin
                if (tmr_done_c) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d     = ST_WAIT;
                tmr_start_c = 1'b1;
                tmr_load_c  = long_q ? LONG_LOAD : SHORT_LOAD;
            end
            ST_WAIT: begin
                if (tmr_done_c) begin
                    if (!init_done_q) begin
                        if (idx_q == 2'(INIT_LEN - 1)) begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            idx_d      = next_idx_c;
                            state_d    = ST_INIT;
                            lcd_rs_d   = 1'b0;
                            lcd_data_d = init_cmd(next_idx_c);
                            long_d     = is_long_cmd(init_cmd(next_idx_c));
                        end
                    end else if (wrap_q) begin
                        wrap_d     = 1'b0;
                        state_d    = ST_WRAP;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = wrap_cmd_c;
                        long_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_SETUP;
                    lcd_rs_d   = in_rs;
                    lcd_data_d = in_data;
                    long_d     = !in_rs && is_long_cmd(in_data);
                    if (in_rs) begin
                        if (col_q == COL_LAST) begin
                            wrap_d = 1'b1;
                            col_d  = '0;
                            line_d = (LINES == 32'd2) ? !line_q : 1'b0;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (is_long_cmd(in_data)) begin
                        line_d = 1'b0;
                        col_d  = '0;
                    end else if (in_data[7]) begin
                        line_d = (LINES == 32'd2) ? in_data[6] : 1'b0;
                        col_d  = (32'(in_data[5:0]) >= COLS) ? COL_LAST : CW'(in_data[5:0]);
                    end
                end
            end
            default: state_d = ST_PWR;
        endcase

        in_ready_d = (state_d == ST_IDLE);
        lcd_e_d    = (state_d == ST_PULSE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWR;
            idx_q       <= 2'd0;
            long_q      <= 1'b0;
            wrap_q      <= 1'b0;
            init_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            line_q      <= 1'b0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            long_q      <= long_d;
            wrap_q      <= wrap_d;
            init_done_q <= init_done_d;
            in_ready_q  <= in_ready_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            line_q      <= line_d;
            col_q       <= col_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign init_done = init_done_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = lcd_data_q;
    assign cur_line  = line_q;
    assign cur_col   = col_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized bench for lcd_ctrl against a write-schedule reference model.
// Cycle n below means "as observed after the n-th rising edge since rst_n release".
module tb_lcd_ctrl;

    localparam int unsigned COLS  = 4;
    localparam int unsigned LINES = 2;
    localparam int unsigned E     = 3;
    localparam int unsigned SW    = 10;
    localparam int unsigned LW    = 40;
    localparam int unsigned PW    = 50;
    localparam int unsigned CW    = $clog2(COLS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_rs = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, init_done, lcd_e, lcd_rs, lcd_rw, cur_line;
    logic [7:0]    lcd_data;
    logic [CW-1:0] cur_col;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .COLS       (COLS),
        .LINES      (LINES),
        .E_CYCLES   (E),
        .SHORT_WAIT (SW),
        .LONG_WAIT  (LW),
        .PWR_WAIT   (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .init_done (init_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .cur_line  (cur_line),
        .cur_col   (cur_col)
    );

    // ---------------- reference model: schedule of bus writes ----------------
    typedef struct {
        int         s;     // cycle the write's rs/data appear on the bus
        bit         rs;
        logic [7:0] d;
    } wr_t;

    wr_t wq[$];
    int  cyc      = 0;
    int  ready_at = 1 << 30;
    int  init_at  = 1 << 30;
    bit  m_line   = 1'b0;
    int  m_col    = 0;
    int  checks   = 0;
    int  errors   = 0;

    task automatic push_wr(input int s, input bit rs, input logic [7:0] d);
        wr_t w;
        w.s = s; w.rs = rs; w.d = d;
        wq.push_back(w);
    endtask

    function automatic int period(input bit long_w);
        return 2 + E + (long_w ? LW : SW);
    endfunction

    task automatic model_reset();
        logic [7:0] cmds [4];
        int s;
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        wq.delete();
        cyc = 0; m_line = 1'b0; m_col = 0;
        s = PW;
        for (int i = 0; i < 4; i++) begin
            push_wr(s, 1'b0, cmds[i]);
            s += period(cmds[i] == 8'h01);
        end
        ready_at = s;
        init_at  = s;
    endtask

    task automatic model_accept(input int t);
        bit long_w;
        long_w = !in_rs && (in_data inside {8'h01, 8'h02, 8'h03});
        push_wr(t, in_rs, in_data);
        ready_at = t + period(long_w);
        if (in_rs) begin
            if (m_col == COLS - 1) begin
                m_line = (LINES == 2) ? !m_line : 1'b0;
                m_col  = 0;
                push_wr(ready_at, 1'b0, m_line ? 8'hC0 : 8'h80);
                ready_at += period(1'b0);
            end else begin
                m_col++;
            end
        end else if (long_w) begin
            m_line = 1'b0;
            m_col  = 0;
        end else if (in_data >= 8'h80) begin
            m_line = (LINES == 2) ? in_data[6] : 1'b0;
            m_col  = (int'(in_data[5:0]) > COLS - 1) ? COLS - 1 : int'(in_data[5:0]);
        end
    endtask

    // Model advances on each edge; accepts when its own ready was high before the edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            if (in_valid && (cyc - 1) >= ready_at) model_accept(cyc);
        end
    end

    function automatic logic [16:0] expect_at(input int n);
        logic       e, rs;
        logic [7:0] d;
        e = 1'b0; rs = 1'b0; d = 8'h00;
        foreach (wq[i]) begin
            if (wq[i].s <= n) begin
                rs = wq[i].rs;
                d  = wq[i].d;
            end
            if (n >= wq[i].s + 1 && n <= wq[i].s + int'(E)) e = 1'b1;
        end
        return {e, rs, 1'b0, d, 1'(n >= ready_at), 1'(n >= init_at), m_line, CW'(m_col)};
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [16:0] exp_v, act_v;
        exp_v = rst_n ? expect_at(cyc) : 17'h0;
        act_v = {lcd_e, lcd_rs, lcd_rw, lcd_data, in_ready, init_done, cur_line, cur_col};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare cyc=%0d {e,rs,rw,data,rdy,init,line,col} got=%h expected=%h",
                     cyc, act_v, exp_v);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp_v);
        end
    endtask

    task automatic wait_until(input int n);
        for (int i = 0; i < 20000 && cyc < n; i++) @(negedge clk);
        if (cyc != n) begin
            errors++;
            $display("FAIL wait_until target=%0d reached=%0d", n, cyc);
        end
    endtask

    // Present one write, hold until accepted; returns the accepting cycle
    task automatic send(input bit rs, input logic [7:0] d, output int t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_rs = rs; in_data = d;
        for (int i = 0; i < 1000; i++) begin
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout data=%h", d);
        end
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        in_valid = 1'b0;
        in_rs    = 1'($urandom);
        in_data  = 8'($urandom);
    endtask

    task automatic check_init();
        wait_until(PW);      chk("init_cmd0", lcd_data, 8'h38); chk("init_rs0", lcd_rs, 0);
                             chk("init_e_low_setup", lcd_e, 0);
        wait_until(PW + 1);  chk("init_e_rise", lcd_e, 1);
        wait_until(PW + 3);  chk("init_e_last", lcd_e, 1);
        wait_until(PW + 4);  chk("init_e_fall", lcd_e, 0);
        wait_until(PW + 15); chk("init_cmd1", lcd_data, 8'h0C);
        wait_until(PW + 30); chk("init_cmd2", lcd_data, 8'h06);
        wait_until(PW + 45); chk("init_cmd3", lcd_data, 8'h01);
        wait_until(139);     chk("ready_before_140", in_ready, 0); chk("init_before_140", init_done, 0);
        wait_until(140);     chk("ready_at_140", in_ready, 1);     chk("init_at_140", init_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t4;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {lcd_e, lcd_rs, lcd_rw, lcd_data, in_ready, init_done, cur_line, cur_col}, 0);
        rst_n = 1'b1;
        check_init();

        // Single character write
        send(1'b1, 8'h41, t);
        chk("char_rs", lcd_rs, 1); chk("char_data", lcd_data, 8'h41); chk("char_col", cur_col, 1);
        wait_until(t + 1);  chk("char_e_rise", lcd_e, 1);
        wait_until(t + 4);  chk("char_e_fall", lcd_e, 0);
        wait_until(t + 14); chk("char_busy", in_ready, 0);
        wait_until(t + 15); chk("char_ready", in_ready, 1);

        // Line wrap both ways
        send(1'b0, 8'h80, t);
        for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h61 + i), t4);
        chk("wrap_line1", cur_line, 1); chk("wrap_col0", cur_col, 0);
        wait_until(t4 + 15); chk("wrap_cmd_c0", lcd_data, 8'hC0); chk("wrap_rs0", lcd_rs, 0);
        wait_until(t4 + 29); chk("wrap_busy", in_ready, 0);
        wait_until(t4 + 30); chk("wrap_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h71 + i), t4);
        chk("wrap_line0", cur_line, 0);
        wait_until(t4 + 15); chk("wrap_cmd_80", lcd_data, 8'h80);

        // Clear, DDRAM addressing, saturation, unrelated instruction
        send(1'b1, 8'h31, t);
        send(1'b0, 8'h01, t);
        chk("clear_col", cur_col, 0); chk("clear_line", cur_line, 0);
        wait_until(t + 44); chk("clear_busy", in_ready, 0);
        wait_until(t + 45); chk("clear_ready", in_ready, 1);
        send(1'b0, 8'hC2, t);
        chk("ddram_line", cur_line, 1); chk("ddram_col", cur_col, 2);
        wait_until(t + 15); chk("ddram_short_wait", in_ready, 1);
        send(1'b0, 8'hFF, t); chk("ddram_sat_col", cur_col, 3);
        send(1'b0, 8'h2A, t); chk("other_cmd_col", cur_col, 3); chk("other_cmd_line", cur_line, 1);
        send(1'b1, 8'h5A, t); chk("wrap_from_l1", cur_line, 0);
        wait_until(t + 15); chk("wrap_from_l1_cmd", lcd_data, 8'h80);

        // in_valid held high with data changing every cycle
        in_valid = 1'b1;
        repeat (400) begin
            @(negedge clk);
            in_rs   = 1'($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
        end
        in_valid = 1'b0;

        // Random traffic
        repeat (3000) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) == 0);
            in_rs    = 1'($urandom);
            case ($urandom_range(0, 4))
                0:       in_data = 8'($urandom_range(1, 3));
                1:       in_data = 8'h80 | 8'($urandom);
                default: in_data = 8'($urandom);
            endcase
        end
        in_valid = 1'b0;

        // Reset in the middle of an E pulse
        send(1'b1, 8'h55, t);
        @(negedge clk);
        chk("pre_reset_e", lcd_e, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs",
               {lcd_e, lcd_rs, lcd_rw, lcd_data, in_ready, init_done, cur_line, cur_col}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_init();
        send(1'b1, 8'h42, t);
        chk("post_reset_col", cur_col, 1);
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
